direction_display_ctrl: RTL and testbench



---
 rtl/dir_disp_pkg.sv | 44 ++++
 rtl/dir_hold_filter.sv | 47 ++++
 rtl/direction_display_ctrl.sv | 163 ++++++++++++++++
 tb/tb_direction_display_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dir_disp_pkg.sv
// Shared types, segment patterns and digit-to-direction mapping for direction_display_ctrl.
package dir_disp_pkg;

    typedef enum logic [1:0] {
        DIR_FWD   = 2'b00,
        DIR_REV   = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        IDLE,
        BLINK,
        SHOW
    } state_e;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // HEX0 = right, HEX1 = left, HEX2 = forward, HEX3 = reverse
    function automatic dir_e digit_dir(input int idx);
        case (idx)
            0:       return DIR_RIGHT;
            1:       return DIR_LEFT;
            2:       return DIR_FWD;
            default: return DIR_REV;
        endcase
    endfunction

    function automatic logic [6:0] digit_seg(input int idx);
        case (idx)
            0:       return SEG_R;
            1:       return SEG_L;
            2:       return SEG_F;
            default: return SEG_B;
        endcase
    endfunction

endpackage

// File: rtl/dir_hold_filter.sv
// Debounces the direction code: a value is committed only after it has been stable
// for HOLD_CYCLES cycles; commit_evt pulses one cycle when the committed value changes.
module dir_hold_filter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] direc,
    output logic [1:0] committed_dir,
    output logic       commit_evt
);
    import dir_disp_pkg::*;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]        candidate_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [1:0]        committed_reg;
    logic              evt_reg;

    // Once stable the counter parks at HOLD_LAST and re-commits every cycle;
    // those repeats are silent because the value equals what is already committed.
    always_ff @(posedge clk) begin
        if (reset) begin
            candidate_reg <= DIR_FWD;
            hold_cnt_reg  <= '0;
            committed_reg <= DIR_FWD;
            evt_reg       <= 1'b0;
        end else begin
            evt_reg <= 1'b0;
            if (direc != candidate_reg) begin
                candidate_reg <= direc;
                hold_cnt_reg  <= '0;
            end else if (hold_cnt_reg == HOLD_LAST) begin
                committed_reg <= candidate_reg;
                evt_reg       <= (candidate_reg != committed_reg);
            end else begin
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
        end
    end

    assign committed_dir = committed_reg;
    assign commit_evt    = evt_reg;

endmodule

// File: rtl/direction_display_ctrl.sv
// Four-digit direction display with hold filter, commit blink and idle dashes.
// Optional change counter port enabled by defining DIR_DISP_CHANGE_CNT_EN.
module direction_display_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int BLINK_HALF  = 3,
    parameter int BLINK_COUNT = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] direc,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3
`ifdef DIR_DISP_CHANGE_CNT_EN
    ,
    output logic [7:0] change_cnt
`endif
);
    import dir_disp_pkg::*;

    localparam int PH_W = (2 * BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;
    localparam int BC_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT + 1) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * BLINK_HALF - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(BLINK_HALF);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_COUNT - 1);
    localparam logic [6:0]      POL_MASK = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;

    logic [1:0] committed_dir;
    logic       commit_evt;

    dir_hold_filter #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_filter (
        .clk          (clk),
        .reset        (reset),
        .direc        (direc),
        .committed_dir(committed_dir),
        .commit_evt   (commit_evt)
    );

    state_e          state_reg, state_next;
    logic [PH_W-1:0] phase_cnt_reg, phase_cnt_next;
    logic [BC_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic            blink_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            phase_cnt_reg <= '0;
            blink_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            phase_cnt_reg <= phase_cnt_next;
            blink_cnt_reg <= blink_cnt_next;
        end
    end

    // Entering SHOW from IDLE never blinks, even if a commit lands on that same edge.
    always_comb begin
        state_next     = state_reg;
        phase_cnt_next = phase_cnt_reg;
        blink_cnt_next = blink_cnt_reg;
        if (!en) begin
            state_next     = IDLE;
            phase_cnt_next = '0;
            blink_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next     = SHOW;
                    phase_cnt_next = '0;
                    blink_cnt_next = '0;
                end
                SHOW: begin
                    if (commit_evt) begin
                        state_next     = BLINK;
                        phase_cnt_next = '0;
                        blink_cnt_next = '0;
                    end
                end
                BLINK: begin
                    if (commit_evt) begin
                        phase_cnt_next = '0;
                        blink_cnt_next = '0;
                    end else if (phase_cnt_reg == PH_LAST) begin
                        phase_cnt_next = '0;
                        if (blink_cnt_reg == BC_LAST) begin
                            state_next     = SHOW;
                            blink_cnt_next = '0;
                        end else begin
                            blink_cnt_next = blink_cnt_reg + 1'b1;
                        end
                    end else begin
                        phase_cnt_next = phase_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next     = IDLE;
                    phase_cnt_next = '0;
                    blink_cnt_next = '0;
                end
            endcase
        end
    end

    assign blink_on = (phase_cnt_next < PH_HALF);

    // Digit outputs are decoded from next-state values so every HEX pin is a flop.
    logic [6:0] hex_bus [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam dir_e       MY_DIR = digit_dir(gi);
            localparam logic [6:0] MY_SEG = digit_seg(gi);

            logic [6:0] seg_next;
            logic [6:0] hex_reg;

            always_comb begin
                seg_next = SEG_BLANK;
                case (state_next)
                    IDLE:    seg_next = SEG_DASH;
                    SHOW:    if (committed_dir == MY_DIR) seg_next = MY_SEG;
                    BLINK:   if (blink_on && committed_dir == MY_DIR) seg_next = MY_SEG;
                    default: seg_next = SEG_BLANK;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    hex_reg <= SEG_BLANK ^ POL_MASK;
                end else begin
                    hex_reg <= seg_next ^ POL_MASK;
                end
            end

            assign hex_bus[gi] = hex_reg;
        end
    endgenerate

    assign HEX0 = hex_bus[0];
    assign HEX1 = hex_bus[1];
    assign HEX2 = hex_bus[2];
    assign HEX3 = hex_bus[3];

`ifdef DIR_DISP_CHANGE_CNT_EN
    logic [7:0] change_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            change_cnt_reg <= 8'd0;
        end else if (commit_evt && change_cnt_reg != 8'hFF) begin
            change_cnt_reg <= change_cnt_reg + 8'd1;
        end
    end

    assign change_cnt = change_cnt_reg;
`endif

endmodule

// File: tb/tb_direction_display_ctrl.sv
// Directed bench for direction_display_ctrl with default parameters.
module tb_direction_display_ctrl;

    localparam logic [6:0] P_R  = 7'b0101111;
    localparam logic [6:0] P_L  = 7'b1000111;
    localparam logic [6:0] P_F  = 7'b0001110;
    localparam logic [6:0] P_B  = 7'b0000011;
    localparam logic [6:0] P_BL = 7'b1111111;
    localparam logic [6:0] P_DS = 7'b0111111;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] direc;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
`ifdef DIR_DISP_CHANGE_CNT_EN
    logic [7:0] change_cnt;
`endif

    int checks = 0;
    int errors = 0;

    direction_display_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .direc(direc),
        .HEX0 (HEX0),
        .HEX1 (HEX1),
        .HEX2 (HEX2),
        .HEX3 (HEX3)
`ifdef DIR_DISP_CHANGE_CNT_EN
        ,
        .change_cnt(change_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_hex(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
        chk({tag, "_hex0"}, {1'b0, HEX0}, {1'b0, e0});
        chk({tag, "_hex1"}, {1'b0, HEX1}, {1'b0, e1});
        chk({tag, "_hex2"}, {1'b0, HEX2}, {1'b0, e2});
        chk({tag, "_hex3"}, {1'b0, HEX3}, {1'b0, e3});
        $display("step %s : HEX0=%b HEX1=%b HEX2=%b HEX3=%b", tag, HEX0, HEX1, HEX2, HEX3);
    endtask

    initial begin
        logic [6:0] e0;
        logic [6:0] e2;

        // Reset held 3 cycles with en=0: blank during reset, dashes afterwards
        reset = 1'b1;
        en    = 1'b0;
        direc = 2'b00;
        tick();
        tick();
        tick();
        chk_hex("reset", P_BL, P_BL, P_BL, P_BL);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_hex($sformatf("idle%0d", i), P_DS, P_DS, P_DS, P_DS);
        end

        // en rises: forward letter one edge later, no blink
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_hex($sformatf("show_fwd%0d", i), P_BL, P_BL, P_F, P_BL);
        end

        // direc 00->11: commit at edge t+4, HEX from t+5, two blink periods, steady at t+17
        direc = 2'b11;
        for (int i = 1; i <= 22; i++) begin
            tick();
            if (i <= 5) e0 = P_BL;
            else if (i <= 8 || (i >= 12 && i <= 14) || i >= 18) e0 = P_R;
            else e0 = P_BL;
            e2 = (i <= 5) ? P_F : P_BL;
            chk_hex($sformatf("blink_r%0d", i), e0, P_BL, e2, P_BL);
        end

        // Back to forward and let the blink finish
        direc = 2'b00;
        for (int i = 0; i < 22; i++) tick();
        chk_hex("settle_fwd", P_BL, P_BL, P_F, P_BL);

        // Three-cycle glitch to left must never commit
        direc = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_hex($sformatf("glitch_on%0d", i), P_BL, P_BL, P_F, P_BL);
        end
        direc = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_hex($sformatf("glitch_off%0d", i), P_BL, P_BL, P_F, P_BL);
        end

        // Left commit, drop en mid-blink, re-raise: steady letter, no blink
        direc = 2'b10;
        for (int i = 0; i < 7; i++) tick();
        chk_hex("blink_l_on", P_BL, P_L, P_BL, P_BL);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_hex($sformatf("drop_en%0d", i), P_DS, P_DS, P_DS, P_DS);
        end
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_hex($sformatf("reraise%0d", i), P_BL, P_L, P_BL, P_BL);
        end

        // Filter tracks in IDLE; en rise coincides with commit pulse: no blink
        en = 1'b0;
        tick();
        direc = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_hex($sformatf("idle_track%0d", i), P_DS, P_DS, P_DS, P_DS);
        end
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_hex($sformatf("simul%0d", i), P_BL, P_BL, P_BL, P_B);
        end

        // Reset in the middle of a blink
        direc = 2'b11;
        for (int i = 0; i < 8; i++) tick();
        chk_hex("pre_reset_blink", P_R, P_BL, P_BL, P_BL);
        reset = 1'b1;
        tick();
        chk_hex("mid_reset", P_BL, P_BL, P_BL, P_BL);
        reset = 1'b0;
        tick();
        chk_hex("post_reset", P_BL, P_BL, P_F, P_BL);

`ifdef DIR_DISP_CHANGE_CNT_EN
        reset = 1'b1;
        direc = 2'b00;
        tick();
        reset = 1'b0;
        chk("cc_reset", change_cnt, 8'd0);
        for (int k = 0; k < 300; k++) begin
            if (k == 2) chk("cc_early", change_cnt, 8'd1);
            direc = (k % 2 == 0) ? 2'b01 : 2'b00;
            for (int i = 0; i < 5; i++) tick();
        end
        tick();
        tick();
        chk("cc_sat", change_cnt, 8'd255);
        $display("step cc_sat : change_cnt=%0d", change_cnt);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("cc_clear", change_cnt, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
